// File: rtl/mrv1_tw_pkg.sv
// mrv1_tw_pkg: shared spawn-state and barrier-entry types for the warp-sync responder.
package mrv1_tw_pkg;
  localparam int TW_NUM_WARPS = 8;
  localparam int TW_NUM_BARRIERS = 8;
  localparam int TW_WID_W = $clog2(TW_NUM_WARPS);
  typedef enum logic {TW_SPAWN_IDLE, TW_SPAWN_BUSY} tw_spawn_state_e;
  typedef struct packed {
    logic [TW_WID_W-1:0] cnt;
    logic [TW_WID_W-1:0] size_m1;
    logic [TW_NUM_WARPS-1:0] wait_mask;
  } tw_bar_entry_t;
endpackage

// File: rtl/mrv1_lsb_enc.sv
// mrv1_lsb_enc: lowest-set-bit encoder returning the bit index and an any-set flag.
module mrv1_lsb_enc #(
  parameter int W = 8,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          vld
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) if (vec[i]) idx = IW'(i);
  end
  assign vld = |vec;
endmodule

// File: rtl/mrv1_tw_sync.sv
// mrv1_tw_sync: warp spawn serializer, active mask and barrier table at the scheduler end.
// Define MRV1_TW_SYNC_ERR_EN to build the sticky protocol-error checks on err_o.
module mrv1_tw_sync
  import mrv1_tw_pkg::*;
#(
  parameter int NUM_TW_P = TW_NUM_WARPS,
  parameter int num_barriers_p = TW_NUM_BARRIERS,
  localparam int wid_width_lp = $clog2(NUM_TW_P),
  localparam int barrier_id_width_lp = $clog2(num_barriers_p)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wspawn_vld_i,
  input  logic [NUM_TW_P-1:0]            wspawn_wmask_i,
  input  logic [31:0]                    wspawn_pc_i,
  output logic                           wspawn_rdy_o,
  input  logic                           barrier_vld_i,
  input  logic [barrier_id_width_lp-1:0] barrier_id_i,
  input  logic [wid_width_lp-1:0]        barrier_size_m1_i,
  input  logic [wid_width_lp-1:0]        barrier_wid_i,
  input  logic                           exit_vld_i,
  input  logic [wid_width_lp-1:0]        exit_wid_i,
  output logic [NUM_TW_P-1:0]            tw_active_o,
  output logic [NUM_TW_P-1:0]            tw_stall_o,
  output logic                           spawn_vld_o,
  output logic [wid_width_lp-1:0]        spawn_wid_o,
  output logic [31:0]                    spawn_pc_o,
  output logic [NUM_TW_P-1:0]            release_o,
  output logic                           err_o
);
  tw_spawn_state_e state, state_n;
  logic [NUM_TW_P-1:0] pend, pend_n, cand, active_n;
  logic [wid_width_lp-1:0] enc_idx;
  logic enc_vld, accept, issue;
  tw_bar_entry_t tbl [num_barriers_p];
  tw_bar_entry_t tbl_n [num_barriers_p];
  tw_bar_entry_t cur;
  logic [wid_width_lp-1:0] sz;
  logic [NUM_TW_P-1:0] arr_bit, release_n, stall_n;
  logic hit;
  assign wspawn_rdy_o = state == TW_SPAWN_IDLE;
  assign accept = wspawn_vld_i & wspawn_rdy_o;
  // In IDLE the encoder looks at the incoming filtered mask so the first strobe leaves with the accept edge.
  assign cand = wspawn_rdy_o ? wspawn_wmask_i & ~tw_active_o : pend;
  assign issue = wspawn_rdy_o ? accept & enc_vld : enc_vld;
  mrv1_lsb_enc #(.W(NUM_TW_P)) u_enc (.vec(cand), .idx(enc_idx), .vld(enc_vld));
  always_comb begin
    pend_n = issue ? cand & ~(NUM_TW_P'(1) << enc_idx) : pend;
    state_n = issue ? TW_SPAWN_BUSY : TW_SPAWN_IDLE;
    active_n = (tw_active_o | (spawn_vld_o ? NUM_TW_P'(1) << spawn_wid_o : '0))
             & ~(exit_vld_i ? NUM_TW_P'(1) << exit_wid_i : '0);
  end
  always_comb begin
    tbl_n = tbl;
    cur = tbl[barrier_id_i];
    arr_bit = NUM_TW_P'(1) << barrier_wid_i;
    sz = cur.cnt != '0 ? cur.size_m1 : barrier_size_m1_i;
    hit = barrier_vld_i && cur.cnt == sz;
    release_n = hit ? cur.wait_mask | arr_bit : '0;
    if (barrier_vld_i) tbl_n[barrier_id_i] = hit ? '0 : {cur.cnt + 1'b1, sz, cur.wait_mask | arr_bit};
    stall_n = '0;
    for (int b = 0; b < num_barriers_p; b++) stall_n = stall_n | tbl_n[b].wait_mask;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= TW_SPAWN_IDLE;
      pend <= '0;
      tw_active_o <= NUM_TW_P'(1);
      tw_stall_o <= '0;
      release_o <= '0;
      spawn_vld_o <= 1'b0;
      spawn_wid_o <= '0;
      spawn_pc_o <= '0;
      for (int b = 0; b < num_barriers_p; b++) tbl[b] <= '0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      tw_active_o <= active_n;
      tw_stall_o <= stall_n;
      release_o <= release_n;
      spawn_vld_o <= issue;
      spawn_wid_o <= issue ? enc_idx : spawn_wid_o;
      spawn_pc_o <= accept ? wspawn_pc_i : spawn_pc_o;
      tbl <= tbl_n;
    end
  end
`ifdef MRV1_TW_SYNC_ERR_EN
  logic err_n;
  assign err_n = err_o | (accept & |(wspawn_wmask_i & tw_active_o))
               | (barrier_vld_i & (|(cur.wait_mask & arr_bit)
                  | (cur.cnt != '0 && cur.size_m1 != barrier_size_m1_i)));
  always_ff @(posedge clk_i) err_o <= rst_i ? 1'b0 : err_n;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mrv1_tw_sync.sv
// tb_mrv1_tw_sync: directed self-checking bench for mrv1_tw_sync.
module tb_mrv1_tw_sync;
  logic clk = 1'b0, rst = 1'b1;
  logic wspawn_vld = 1'b0, wspawn_rdy;
  logic [7:0] wspawn_wmask = '0;
  logic [31:0] wspawn_pc = '0;
  logic barrier_vld = 1'b0;
  logic [2:0] barrier_id = '0, barrier_size_m1 = '0, barrier_wid = '0;
  logic exit_vld = 1'b0;
  logic [2:0] exit_wid = '0;
  logic [7:0] tw_active, tw_stall, release_m;
  logic spawn_vld, err;
  logic [2:0] spawn_wid;
  logic [31:0] spawn_pc;
  int tests_run = 0, tests_failed = 0;
`ifdef MRV1_TW_SYNC_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  mrv1_tw_sync dut (
    .clk_i(clk), .rst_i(rst),
    .wspawn_vld_i(wspawn_vld), .wspawn_wmask_i(wspawn_wmask), .wspawn_pc_i(wspawn_pc), .wspawn_rdy_o(wspawn_rdy),
    .barrier_vld_i(barrier_vld), .barrier_id_i(barrier_id), .barrier_size_m1_i(barrier_size_m1), .barrier_wid_i(barrier_wid),
    .exit_vld_i(exit_vld), .exit_wid_i(exit_wid),
    .tw_active_o(tw_active), .tw_stall_o(tw_stall),
    .spawn_vld_o(spawn_vld), .spawn_wid_o(spawn_wid), .spawn_pc_o(spawn_pc),
    .release_o(release_m), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++; if (tw_active !== 8'h01) begin tests_failed++; $display("FAIL %s active: got %h want 01", tag, tw_active); end
    tests_run++; if (tw_stall !== 8'h00) begin tests_failed++; $display("FAIL %s stall: got %h want 00", tag, tw_stall); end
    tests_run++; if (release_m !== 8'h00) begin tests_failed++; $display("FAIL %s release: got %h want 00", tag, release_m); end
    tests_run++; if (spawn_vld !== 1'b0) begin tests_failed++; $display("FAIL %s spawn_vld: got %b want 0", tag, spawn_vld); end
    tests_run++; if (spawn_wid !== 3'd0) begin tests_failed++; $display("FAIL %s spawn_wid: got %0d want 0", tag, spawn_wid); end
    tests_run++; if (spawn_pc !== 32'h0) begin tests_failed++; $display("FAIL %s spawn_pc: got %h want 0", tag, spawn_pc); end
    tests_run++; if (wspawn_rdy !== 1'b1) begin tests_failed++; $display("FAIL %s rdy: got %b want 1", tag, wspawn_rdy); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL %s err: got %b want 0", tag, err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");
  endtask

  task automatic test_spawn();
    wspawn_vld = 1'b1; wspawn_wmask = 8'b0000_1110; wspawn_pc = 32'h100;
    tick();
    wspawn_vld = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tests_run++; if (spawn_vld !== 1'b1 || spawn_wid !== 3'(k) || spawn_pc !== 32'h100)
        begin tests_failed++; $display("FAIL spawn strobe %0d: got vld=%b wid=%0d pc=%h want 1 %0d 100", k, spawn_vld, spawn_wid, spawn_pc, k); end
      tests_run++; if (wspawn_rdy !== 1'b0) begin tests_failed++; $display("FAIL spawn rdy cycle %0d: got %b want 0", k, wspawn_rdy); end
      tick();
    end
    tests_run++; if (spawn_vld !== 1'b0) begin tests_failed++; $display("FAIL spawn done vld: got %b want 0", spawn_vld); end
    tests_run++; if (wspawn_rdy !== 1'b1) begin tests_failed++; $display("FAIL spawn done rdy: got %b want 1", wspawn_rdy); end
    tests_run++; if (tw_active !== 8'h0F) begin tests_failed++; $display("FAIL spawn active: got %h want 0f", tw_active); end
  endtask

  task automatic test_spawn_filtered();
    rst = 1'b1; tick(); rst = 1'b0;
    wspawn_vld = 1'b1; wspawn_wmask = 8'b0000_0001; wspawn_pc = 32'h180;
    tick();
    wspawn_vld = 1'b0;
    tests_run++; if (spawn_vld !== 1'b0) begin tests_failed++; $display("FAIL filtered vld: got %b want 0", spawn_vld); end
    tests_run++; if (wspawn_rdy !== 1'b1) begin tests_failed++; $display("FAIL filtered rdy: got %b want 1", wspawn_rdy); end
    tests_run++; if (err !== ERR_EXP) begin tests_failed++; $display("FAIL filtered err: got %b want %b", err, ERR_EXP); end
    tick();
    tests_run++; if (spawn_vld !== 1'b0 || tw_active !== 8'h01) begin tests_failed++; $display("FAIL filtered idle: got vld=%b active=%h want 0 01", spawn_vld, tw_active); end
    rst = 1'b1; tick(); rst = 1'b0;
    wspawn_vld = 1'b1; wspawn_wmask = 8'b0000_1110; wspawn_pc = 32'h100;
    tick();
    wspawn_vld = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_barrier();
    logic [7:0] exp_stall;
    barrier_vld = 1'b1; barrier_id = 3'd2; barrier_size_m1 = 3'd3;
    exp_stall = 8'h00;
    for (int w = 0; w < 3; w++) begin
      barrier_wid = 3'(w);
      exp_stall[w] = 1'b1;
      tick();
      tests_run++; if (tw_stall !== exp_stall || release_m !== 8'h00)
        begin tests_failed++; $display("FAIL barrier arrive %0d: got stall=%h rel=%h want %h 00", w, tw_stall, release_m, exp_stall); end
    end
    barrier_wid = 3'd3;
    tick();
    barrier_vld = 1'b0;
    tests_run++; if (release_m !== 8'h0F) begin tests_failed++; $display("FAIL barrier release: got %h want 0f", release_m); end
    tests_run++; if (tw_stall !== 8'h00) begin tests_failed++; $display("FAIL barrier stall clear: got %h want 00", tw_stall); end
    tick();
    tests_run++; if (release_m !== 8'h00) begin tests_failed++; $display("FAIL barrier pulse width: got %h want 00", release_m); end
  endtask

  task automatic test_size_zero();
    barrier_vld = 1'b1; barrier_id = 3'd4; barrier_size_m1 = 3'd0; barrier_wid = 3'd5;
    tick();
    barrier_vld = 1'b0;
    tests_run++; if (release_m !== 8'h20 || tw_stall !== 8'h00)
      begin tests_failed++; $display("FAIL size0 release: got rel=%h stall=%h want 20 00", release_m, tw_stall); end
    tick();
    tests_run++; if (release_m !== 8'h00 || tw_stall !== 8'h00)
      begin tests_failed++; $display("FAIL size0 after: got rel=%h stall=%h want 00 00", release_m, tw_stall); end
  endtask

  task automatic test_simultaneous();
    wspawn_vld = 1'b1; wspawn_wmask = 8'h10; wspawn_pc = 32'h200;
    barrier_vld = 1'b1; barrier_id = 3'd1; barrier_size_m1 = 3'd1; barrier_wid = 3'd0;
    tick();
    wspawn_vld = 1'b0; barrier_vld = 1'b0;
    tests_run++; if (spawn_vld !== 1'b1 || spawn_wid !== 3'd4 || spawn_pc !== 32'h200)
      begin tests_failed++; $display("FAIL simul spawn: got vld=%b wid=%0d pc=%h want 1 4 200", spawn_vld, spawn_wid, spawn_pc); end
    tests_run++; if (tw_stall !== 8'h01) begin tests_failed++; $display("FAIL simul stall: got %h want 01", tw_stall); end
    exit_vld = 1'b1; exit_wid = 3'd4;
    tick();
    exit_vld = 1'b0;
    tests_run++; if (tw_active !== 8'h0F || wspawn_rdy !== 1'b1)
      begin tests_failed++; $display("FAIL simul exit wins: got active=%h rdy=%b want 0f 1", tw_active, wspawn_rdy); end
    barrier_vld = 1'b1; barrier_wid = 3'd1;
    tick();
    barrier_vld = 1'b0;
    tests_run++; if (release_m !== 8'h03 || tw_stall !== 8'h00 || tw_active !== 8'h0F)
      begin tests_failed++; $display("FAIL simul barrier1: got rel=%h stall=%h active=%h want 03 00 0f", release_m, tw_stall, tw_active); end
  endtask

  task automatic test_reset_mid_spawn();
    wspawn_vld = 1'b1; wspawn_wmask = 8'h70; wspawn_pc = 32'h300;
    tick();
    wspawn_vld = 1'b0;
    tests_run++; if (spawn_vld !== 1'b1 || spawn_wid !== 3'd4)
      begin tests_failed++; $display("FAIL midrst first strobe: got vld=%b wid=%0d want 1 4", spawn_vld, spawn_wid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++; if (spawn_vld !== 1'b0 || tw_active !== 8'h01)
        begin tests_failed++; $display("FAIL midrst quiet %0d: got vld=%b active=%h want 0 01", k, spawn_vld, tw_active); end
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_barrier();
    test_size_zero();
    test_simultaneous();
    test_reset_mid_spawn();
    test_spawn_filtered();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mrv1_tw_sync.md
# mrv1_tw_sync

Warp-synchronization responder at the scheduler end of the thread-control interface. Consumes the wspawn and barrier requests issued by the thread-control execution unit. Maintains the per-warp active mask, serializes spawns into per-warp PC loads, and tracks barrier arrivals. It stalls warps at a barrier and releases them when the barrier is full.

## Interface
- NUM_TW_P, 8: number of warps.
- num_barriers_p, 8: number of hardware barriers.
- wid_width_lp, $clog2(NUM_TW_P): warp-id width.
- barrier_id_width_lp, $clog2(num_barriers_p): barrier-id width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- wspawn_vld_i  in  1  spawn request.
- wspawn_wmask_i  in  NUM_TW_P  warps to spawn.
- wspawn_pc_i  in  32  start PC for spawned warps.
- wspawn_rdy_o  out  1  spawn request can be accepted.
- barrier_vld_i  in  1  barrier arrival.
- barrier_id_i  in  barrier_id_width_lp  barrier index.
- barrier_size_m1_i  in  wid_width_lp  participating warps minus one.
- barrier_wid_i  in  wid_width_lp  arriving warp.
- exit_vld_i  in  1  warp termination.
- exit_wid_i  in  wid_width_lp  terminating warp.
- tw_active_o  out  NUM_TW_P  active warp mask.
- tw_stall_o  out  NUM_TW_P  warps blocked at a barrier.
- spawn_vld_o  out  1  per-warp PC load strobe.
- spawn_wid_o  out  wid_width_lp  warp to load.
- spawn_pc_o  out  32  PC to load.
- release_o  out  NUM_TW_P  one-cycle pulse of warps released from a barrier.
- err_o  out  1  protocol error, sticky.

## Operation
Spawn FSM:
- States are IDLE and SPAWN.
- wspawn_rdy_o = (state == IDLE).
- A spawn is accepted when wspawn_vld_i & wspawn_rdy_o.
- On accept, latch pend = wspawn_wmask_i & ~tw_active_o and latch pc.
- If pend == 0 after filtering, stay in IDLE.
- Otherwise go to SPAWN.
- In SPAWN, each cycle:
  - Select the lowest set bit of pend.
  - Drive spawn_vld_o=1, spawn_wid_o=that bit's index, spawn_pc_o=latched pc.
  - Clear the bit in pend and set it in the active mask.
- Return to IDLE in the cycle the last bit is issued.

Active mask:
- exit_vld_i clears bit exit_wid_i.
- If a spawn-set and an exit hit the same warp in the same cycle, exit wins.

Barrier table, one entry per barrier:
- Each entry holds cnt[wid_width_lp], wait[NUM_TW_P] and size_m1.
- On arrival with cnt == size_m1 (size taken from the entry if cnt != 0, else from the input):
  - release_o = wait | (1<<wid) on the next cycle.
  - Clear the entry's cnt and wait.
- Otherwise: cnt++, set wait[wid], latch size_m1 when cnt was 0.
- size_m1 == 0 releases immediately: release_o contains only the arriving warp, and it never stalls.
- tw_stall_o = OR of all wait vectors, registered.

Concurrency:
- Barrier and spawn requests may arrive in the same cycle. Both are processed.
- Arrivals at different barriers in consecutive cycles are independent.
- Exit of a waiting warp does not modify barrier state.

## Timing
- Reset values:
  - tw_active_o = 'b1: warp 0 active, all other warps inactive.
  - tw_stall_o = 0, release_o = 0, spawn_vld_o = 0, spawn_wid_o = 0, spawn_pc_o = 0, err_o = 0.
  - wspawn_rdy_o = 1; FSM in IDLE; all barrier entries cleared.
- A reset asserted mid-spawn or mid-barrier clears all state at that edge. Pending spawns are discarded.
- Spawn latency:
  - The first spawn_vld_o comes one cycle after accept.
  - N pending warps take N consecutive cycles.
  - wspawn_rdy_o returns high the cycle after the last strobe.
- The tw_active_o bit rises in the cycle after its spawn_vld_o strobe.
- Barrier:
  - tw_stall_o for the arriving warp, or release_o, is visible one cycle after barrier_vld_i.
  - The stall bit falls in the same cycle release_o pulses.
- All outputs are registered.

## Configuration
- MRV1_TW_SYNC_ERR_EN defined: err_o is set and held until reset on any of:
  - arrival of a warp already in wait of that barrier;
  - size_m1 mismatch versus the latched value;
  - spawn mask containing an already-active warp.
- Erroneous barrier arrivals are otherwise still processed normally.
- Macro undefined: checks are not built and err_o is tied 0.

## Structure
- Package mrv1_tw_pkg holds:
  - the spawn-state enum (TW_SPAWN_IDLE, TW_SPAWN_BUSY);
  - the typedef struct for a barrier entry (cnt, size_m1, wait).
- Sub-module mrv1_lsb_enc: lowest-set-bit encoder, parameterized width, outputs index and valid. Used by the spawn FSM.

## Test plan
- Reset, then wspawn mask 8'b0000_1110 with pc 0x100:
  - spawn_vld_o for wids 1, 2, 3 on cycles +1, +2, +3;
  - wspawn_rdy_o low for cycles +1 to +3, high again on cycle +4;
  - tw_active_o = 8'h0F.
- Spawn mask 8'b0000_0001 with only warp 0 active: no strobe; wspawn_rdy_o stays 1; err_o=1 with MRV1_TW_SYNC_ERR_EN.
- Barrier 2 with size_m1=3, arrivals from wids 0, 1, 2:
  - tw_stall_o = 8'h07;
  - wid 3 arrives: release_o = 8'h0F for one cycle, then tw_stall_o = 0.
- Barrier with size_m1=0 from wid 5: release_o = 8'h20 the next cycle; tw_stall_o never set.
- Simultaneous events:
  - same-cycle spawn of warp 4 and barrier-1 arrival of wid 0 (size_m1=1): both processed;
  - exit of wid 4 during its spawn strobe: tw_active_o bit 4 stays 0.
- rst_i mid-spawn after 1 of 3 strobes: all outputs return to reset values at the next edge; no further strobes.
